// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths and fetch-state enum for the instruction fetch path
package pipeline_pkg;
  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction memory and IF/ID handshake bundle for fetch_queue
interface fetch_queue_if #(
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int DATA_W = pipeline_pkg::DATA_W
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - register FIFO of {pc, instr} entries with flush and occupancy
module fq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 40,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] fill;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fill  = wr_ptr - rd_ptr;
  assign count = CNT_W'(fill);
  assign valid = (fill != '0);
  assign full  = (fill == PTR_W'(DEPTH));
  assign rdata = valid ? mem[rd_ptr[IDX_W-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[IDX_W-1:0]] <= wdata;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(pop && !valid));
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
  assert property (@(posedge clk) disable iff (!rst_n) fill <= PTR_W'(DEPTH));
endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction prefetch queue with branch redirect and kill handling
module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = pipeline_pkg::ADDR_W,
  parameter int              DATA_W   = pipeline_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  fetch_queue_if.master              bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  import pipeline_pkg::*;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  fetch_state_t              state, state_nxt;
  logic [ADDR_W-1:0]         fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0]         kill_addr, kill_addr_nxt;
  logic                      started;
  logic                      req;
  logic                      push;
  logic                      pop;
  logic                      full;
  logic [ADDR_W+DATA_W-1:0]  head;

  // started holds off the first request until rst_n has been sampled high once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      kill_addr <= '0;
      started   <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      kill_addr <= kill_addr_nxt;
      started   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    kill_addr_nxt = kill_addr;
    req           = 1'b0;
    bus.imem_addr = fetch_pc;
    push          = 1'b0;
    case (state)
      RUN: begin
        req  = started && !full;
        push = req && bus.imem_ack && !redirect;
        if (push) fetch_pc_nxt = fetch_pc + PC_STEP;
        // An outstanding unacked fetch must finish at its old address before restarting.
        if (redirect && req && !bus.imem_ack) begin
          state_nxt     = KILL;
          kill_addr_nxt = fetch_pc;
        end
      end
      KILL: begin
        req           = 1'b1;
        bus.imem_addr = kill_addr;
        if (bus.imem_ack) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (redirect) fetch_pc_nxt = {redirect_pc[ADDR_W-1:2], 2'b00};
  end

  assign bus.imem_req = req;
  assign pop          = bus.out_valid && bus.out_ready && !redirect;

  fq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({fetch_pc, bus.imem_rdata}),
    .rdata (head),
    .valid (bus.out_valid),
    .full  (full),
    .count (occupancy)
  );

  assign bus.out_pc    = head[ADDR_W+DATA_W-1:DATA_W];
  assign bus.out_instr = head[DATA_W-1:0];
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
  import pipeline_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int DW    = 32;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          redirect    = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [2:0]    occupancy;
  int            n_checks    = 0;
  int            n_errors    = 0;

  fetch_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] patt(input logic [AW-1:0] a);
    return {8'hC0, ~a, 8'h5A, a};
  endfunction

  assign bus.imem_rdata = patt(bus.imem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset(input logic ack, input logic ready);
    rst_n         = 1'b0;
    redirect      = 1'b0;
    bus.imem_ack  = ack;
    bus.out_ready = ready;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] pc;
    logic [AW-1:0] wrap_pc [4];
    wrap_pc[0] = 8'hF8; wrap_pc[1] = 8'hFC; wrap_pc[2] = 8'h00; wrap_pc[3] = 8'h04;

    // 1: reset state, then streaming at one instruction per cycle
    bus.imem_ack  = 1'b1;
    bus.out_ready = 1'b1;
    tick; tick; settle;
    check("rst_req", bus.imem_req, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_pc", bus.out_pc, 0);
    check("rst_instr", bus.out_instr, 0);
    rst_n = 1'b1;
    settle;
    check("rel_req_before_edge", bus.imem_req, 0);
    tick; settle;
    check("t1_first_req", bus.imem_req, 1);
    check("t1_first_addr", bus.imem_addr, 8'h00);
    check("t1_first_valid", bus.out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      tick; settle;
      check("t1_valid", bus.out_valid, 1);
      check("t1_pc", bus.out_pc, AW'(4 * i));
      check("t1_instr", bus.out_instr, patt(AW'(4 * i)));
      check("t1_addr", bus.imem_addr, AW'(4 * (i + 1)));
      check("t1_occ", occupancy, 1);
    end

    // 2: back-pressure fills the queue, then drains in order
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick;
    settle;
    check("t2_full_occ", occupancy, 4);
    check("t2_full_req", bus.imem_req, 0);
    check("t2_full_head", bus.out_pc, 8'h00);
    tick;
    bus.out_ready = 1'b1;
    settle;
    check("t2_pop_no_req", bus.imem_req, 0);
    check("t2_pop0_pc", bus.out_pc, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      tick; settle;
      check("t2_drain_pc", bus.out_pc, AW'(4 * k));
      if (k == 1) begin
        check("t2_resume_req", bus.imem_req, 1);
        check("t2_resume_addr", bus.imem_addr, 8'h10);
        check("t2_resume_occ", occupancy, 3);
      end
    end

    // 3: redirect during a delayed ack kills the in-flight fetch
    do_reset(1'b0, 1'b1);
    tick;
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    settle;
    check("t3_wait1_addr", bus.imem_addr, 8'h00);
    check("t3_wait1_req", bus.imem_req, 1);
    tick;
    redirect = 1'b0;
    settle;
    check("t3_kill_addr", bus.imem_addr, 8'h00);
    check("t3_kill_req", bus.imem_req, 1);
    check("t3_kill_occ", occupancy, 0);
    tick;
    bus.imem_ack = 1'b1;
    settle;
    check("t3_ack_addr", bus.imem_addr, 8'h00);
    tick; settle;
    check("t3_new_addr", bus.imem_addr, 8'h40);
    check("t3_no_stale", bus.out_valid, 0);
    tick; settle;
    check("t3_out_pc", bus.out_pc, 8'h40);
    check("t3_out_instr", bus.out_instr, patt(8'h40));
    check("t3_next_addr", bus.imem_addr, 8'h44);

    // 4: redirect with a misaligned target flushes three queued entries
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick;
    redirect      = 1'b1;
    redirect_pc   = 8'h23;
    bus.out_ready = 1'b1;
    settle;
    check("t4_pre_occ", occupancy, 3);
    tick;
    redirect = 1'b0;
    settle;
    check("t4_flush_occ", occupancy, 0);
    check("t4_flush_valid", bus.out_valid, 0);
    check("t4_addr", bus.imem_addr, 8'h20);
    tick; settle;
    check("t4_out_pc", bus.out_pc, 8'h20);
    check("t4_occ", occupancy, 1);
    tick; settle;
    check("t4_out_pc2", bus.out_pc, 8'h24);

    // 5: sequential fetch wraps modulo 2^ADDR_W
    do_reset(1'b1, 1'b1);
    tick;
    redirect    = 1'b1;
    redirect_pc = 8'hF8;
    settle;
    tick;
    redirect = 1'b0;
    settle;
    check("t5_addr0", bus.imem_addr, 8'hF8);
    for (int i = 0; i < 4; i++) begin
      tick; settle;
      pc = wrap_pc[i] + 8'h04;
      check("t5_pc", bus.out_pc, wrap_pc[i]);
      check("t5_addr", bus.imem_addr, pc);
    end
    check("t5_instr", bus.out_instr, patt(8'h04));

    // 6: asynchronous reset mid-stream
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick;
    settle;
    check("t6_pre_occ", occupancy, 3);
    check("t6_pre_req", bus.imem_req, 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", bus.out_valid, 0);
    check("t6_async_req", bus.imem_req, 0);
    check("t6_async_occ", occupancy, 0);
    tick;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick; settle;
    check("t6_restart_req", bus.imem_req, 1);
    check("t6_restart_addr", bus.imem_addr, 8'h00);
    tick; settle;
    check("t6_restart_pc", bus.out_pc, 8'h00);
    check("t6_restart_valid", bus.out_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
